// File: rtl/aes128_decrypt_iter.sv
// Iterative AES-128 decryption core (FIPS-197 inverse cipher).
// A loaded key is expanded forward once to K10, which is stored. Each block
// then walks the key schedule backwards on the fly, ROUNDS_PER_CYCLE rounds
// per clock, with valid/ready handshakes on key, input and output.
module aes128_decrypt_iter #(
   parameter int ROUNDS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [127:0] key,
   input  logic         key_valid,
   output logic         key_ready,
   input  logic [127:0] data_in,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [127:0] data_out,
   output logic         out_valid,
   input  logic         out_ready
);

   // Only divisors of 10 give a whole number of cycles per pass.
   if (!(ROUNDS_PER_CYCLE == 1 || ROUNDS_PER_CYCLE == 2 || ROUNDS_PER_CYCLE == 5)) begin : g_bad_rpc
      $error("aes128_decrypt_iter: ROUNDS_PER_CYCLE must be 1, 2 or 5");
   end

   localparam int         NCYC     = 10 / ROUNDS_PER_CYCLE;
   localparam logic [3:0] LAST_CYC = 4'(NCYC - 1);

   localparam logic [2:0] ST_IDLE  = 3'd0;
   localparam logic [2:0] ST_KEXP  = 3'd1;
   localparam logic [2:0] ST_READY = 3'd2;
   localparam logic [2:0] ST_DEC   = 3'd3;
   localparam logic [2:0] ST_DONE  = 3'd4;

   // State as 16 bytes; byte0 of FIPS order lives in element 15 (bits 127:120).
   typedef logic [15:0][7:0] state_t;

   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (8'h1b & {8{a[7]}});
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = xtime(aa);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 (2+4+...+128); zero maps to zero.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      logic [7:0] p;
      r = 8'h01;
      p = a;
      for (int i = 1; i < 8; i++) begin
         p = gf_mul(p, p);
         r = gf_mul(r, p);
      end
      return r;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] b;
      b = gf_inv(x);
      return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] x);
      logic [7:0] b;
      b = {x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05;
      return gf_inv(b);
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   // One forward key-schedule step: K(r-1) -> K(r) using rcon(r).
   function automatic logic [127:0] fwd_key_step(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w4, w5, w6, w7;
      w4 = k[127:96] ^ sub_word({k[23:0], k[31:24]}) ^ {rc, 24'h0};
      w5 = k[95:64] ^ w4;
      w6 = k[63:32] ^ w5;
      w7 = k[31:0]  ^ w6;
      return {w4, w5, w6, w7};
   endfunction

   // One inverse key-schedule step: K(r) -> K(r-1) using rcon(r).
   function automatic logic [127:0] inv_key_step(input logic [127:0] k, input logic [7:0] rc);
      logic [31:0] w0, w1, w2, w3;
      w3 = k[31:0]  ^ k[63:32];
      w2 = k[63:32] ^ k[95:64];
      w1 = k[95:64] ^ k[127:96];
      w0 = k[127:96] ^ sub_word({w3[23:0], w3[31:24]}) ^ {rc, 24'h0};
      return {w0, w1, w2, w3};
   endfunction

   // Step rcon one position back in the 01,02,..,80,1b,36 sequence.
   function automatic logic [7:0] rcon_prev(input logic [7:0] rc);
      return rc[0] ? (((rc ^ 8'h1b) >> 1) | 8'h80) : (rc >> 1);
   endfunction

   function automatic state_t inv_shift_rows(input state_t a);
      state_t o;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[15 - (r + 4 * c)] = a[15 - (r + 4 * ((c - r + 4) % 4))];
         end
      end
      return o;
   endfunction

   function automatic state_t inv_sub_bytes(input state_t a);
      state_t o;
      for (int i = 0; i < 16; i++) o[i] = inv_sbox(a[i]);
      return o;
   endfunction

   function automatic state_t inv_mix_columns(input state_t a);
      state_t o;
      logic [7:0] a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = a[15 - 4 * c];
         a1 = a[14 - 4 * c];
         a2 = a[13 - 4 * c];
         a3 = a[12 - 4 * c];
         o[15 - 4 * c] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
         o[14 - 4 * c] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
         o[13 - 4 * c] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
         o[12 - 4 * c] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
      end
      return o;
   endfunction

   logic [2:0]   state_q,     state_d;
   logic [127:0] rk_q,        rk_d;
   logic [7:0]   rcon_q,      rcon_d;
   logic [127:0] k10_q,       k10_d;
   logic [127:0] st_q,        st_d;
   logic [3:0]   round_q,     round_d;
   logic [127:0] data_out_q,  data_out_d;
   logic         out_valid_q, out_valid_d;

   // Handshake readiness: key load always wins over a block in READY.
   assign key_ready = (state_q == ST_IDLE) || (state_q == ST_READY);
   assign in_ready  = (state_q == ST_READY) && !key_valid;
   assign data_out  = data_out_q;
   assign out_valid = out_valid_q;

   // Next-state, key-schedule and round datapath for the whole FSM.
   always_comb begin
      logic [127:0] k;
      logic [7:0]   rc;
      state_t       s;
      int           r_idx;
      state_d     = state_q;
      rk_d        = rk_q;
      rcon_d      = rcon_q;
      k10_d       = k10_q;
      st_d        = st_q;
      round_d     = round_q;
      data_out_d  = data_out_q;
      out_valid_d = out_valid_q;
      k           = rk_q;
      rc          = rcon_q;
      s           = st_q;
      r_idx       = 0;
      case (state_q)
         ST_IDLE, ST_READY: begin
            if (key_valid) begin
               rk_d    = key;
               rcon_d  = 8'h01;
               round_d = 4'd0;
               state_d = ST_KEXP;
            end else if (in_valid && state_q == ST_READY) begin
               st_d    = data_in ^ k10_q;
               rk_d    = inv_key_step(k10_q, 8'h36);
               rcon_d  = 8'h1b;
               round_d = 4'd0;
               state_d = ST_DEC;
            end
         end
         ST_KEXP: begin
            for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
               k  = fwd_key_step(k, rc);
               rc = xtime(rc);
            end
            rk_d    = k;
            rcon_d  = rc;
            round_d = round_q + 4'd1;
            if (round_q == LAST_CYC) begin
               k10_d   = k;
               round_d = 4'd0;
               state_d = ST_READY;
            end
         end
         ST_DEC: begin
            for (int j = 0; j < ROUNDS_PER_CYCLE; j++) begin
               r_idx = 9 - (int'(round_q) * ROUNDS_PER_CYCLE + j);
               s = inv_sub_bytes(inv_shift_rows(s)) ^ k;
               if (r_idx != 0) s = inv_mix_columns(s);
               k  = inv_key_step(k, rc);
               rc = rcon_prev(rc);
            end
            st_d    = s;
            rk_d    = k;
            rcon_d  = rc;
            round_d = round_q + 4'd1;
            if (round_q == LAST_CYC) begin
               data_out_d  = s;
               out_valid_d = 1'b1;
               round_d     = 4'd0;
               state_d     = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ST_READY;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers; reset discards any key or block in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         rk_q        <= '0;
         rcon_q      <= '0;
         k10_q       <= '0;
         st_q        <= '0;
         round_q     <= '0;
         data_out_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         rk_q        <= rk_d;
         rcon_q      <= rcon_d;
         k10_q       <= k10_d;
         st_q        <= st_d;
         round_q     <= round_d;
         data_out_q  <= data_out_d;
         out_valid_q <= out_valid_d;
      end
   end

endmodule

// File: tb/tb_aes128_decrypt_iter.sv
// Testbench for aes128_decrypt_iter: three instances (1, 2 and 5 rounds per
// cycle) against FIPS-197 vectors and a forward-cipher reference model, with
// a scoreboard queue filled on input handshakes and drained on output ones.
module tb_aes128_decrypt_iter;

   localparam int NI = 3;
   localparam int RPC_T[NI] = '{1, 2, 5};

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_K10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

   logic         clk = 1'b0;
   logic         rst;
   logic [127:0] key_a       [NI];
   logic         key_valid_a [NI];
   logic         key_ready_a [NI];
   logic [127:0] data_in_a   [NI];
   logic         in_valid_a  [NI];
   logic         in_ready_a  [NI];
   logic [127:0] data_out_a  [NI];
   logic         out_valid_a [NI];
   logic         out_ready_a [NI];

   int           checks = 0;
   int           errors = 0;
   logic [127:0] exp_q[$];
   int           exp_idx_q[$];
   logic         rand_ready = 1'b0;
   logic [7:0]   sbox_t [256];

   // Free-running clock.
   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      aes128_decrypt_iter #(.ROUNDS_PER_CYCLE(RPC_T[g])) dut (
         .clk       (clk),
         .rst       (rst),
         .key       (key_a[g]),
         .key_valid (key_valid_a[g]),
         .key_ready (key_ready_a[g]),
         .data_in   (data_in_a[g]),
         .in_valid  (in_valid_a[g]),
         .in_ready  (in_ready_a[g]),
         .data_out  (data_out_a[g]),
         .out_valid (out_valid_a[g]),
         .out_ready (out_ready_a[g])
      );
   end

   task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] mul2(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   // S-box table built with the classic p/q generator walk over GF(2^8).
   task automatic buildSbox();
      logic [7:0] p, q, x;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ {q[6:0], 1'b0};
         q = q ^ {q[5:0], 2'b0};
         q = q ^ {q[3:0], 4'b0};
         if (q[7]) q = q ^ 8'h09;
         x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]} ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
         sbox_t[p] = x ^ 8'h63;
      end while (p != 8'h01);
      sbox_t[0] = 8'h63;
   endtask

   // Forward AES-128 cipher on byte arrays, key expanded round by round.
   function automatic logic [127:0] modelEncrypt(input logic [127:0] k, input logic [127:0] pt);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   rk [16];
      logic [7:0]   tw [4];
      logic [7:0]   rc;
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] res;
      for (int i = 0; i < 16; i++) begin
         rk[i] = k[127 - 8 * i -: 8];
         s[i]  = pt[127 - 8 * i -: 8] ^ rk[i];
      end
      rc = 8'h01;
      for (int rnd = 1; rnd <= 10; rnd++) begin
         tw[0] = sbox_t[rk[13]] ^ rc;
         tw[1] = sbox_t[rk[14]];
         tw[2] = sbox_t[rk[15]];
         tw[3] = sbox_t[rk[12]];
         for (int r = 0; r < 4; r++) rk[r] = rk[r] ^ tw[r];
         for (int c = 1; c < 4; c++)
            for (int r = 0; r < 4; r++) rk[4 * c + r] = rk[4 * c + r] ^ rk[4 * (c - 1) + r];
         rc = mul2(rc);
         for (int i = 0; i < 16; i++) t[i] = sbox_t[s[i]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[r + 4 * c] = t[r + 4 * ((c + r) % 4)];
         if (rnd < 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4 * c]; a1 = s[4 * c + 1]; a2 = s[4 * c + 2]; a3 = s[4 * c + 3];
               s[4 * c]     = mul2(a0) ^ mul2(a1) ^ a1 ^ a2 ^ a3;
               s[4 * c + 1] = a0 ^ mul2(a1) ^ mul2(a2) ^ a2 ^ a3;
               s[4 * c + 2] = a0 ^ a1 ^ mul2(a2) ^ mul2(a3) ^ a3;
               s[4 * c + 3] = mul2(a0) ^ a0 ^ a1 ^ a2 ^ mul2(a3);
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ rk[i];
      end
      for (int i = 0; i < 16; i++) res[127 - 8 * i -: 8] = s[i];
      return res;
   endfunction

   // Load a key and wait until expansion finishes (key_ready back high).
   task automatic loadKey(input int idx, input logic [127:0] k);
      int n;
      key_a[idx]       = k;
      key_valid_a[idx] = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (key_ready_a[idx] !== 1'b1 && n < 300);
      @(posedge clk); #1;
      key_valid_a[idx] = 1'b0;
      if (n >= 300) checkOutput("key_accept_timeout", 128'd0, 128'd1);
      n = 0;
      do begin @(negedge clk); n++; end while (key_ready_a[idx] !== 1'b1 && n < 60);
      if (n >= 60) checkOutput("kexp_timeout", 128'd0, 128'd1);
      @(posedge clk); #1;
   endtask

   // Offer one ciphertext block; push the expected plaintext on handshake.
   task automatic applyStimulus(input int idx, input logic [127:0] ct, input logic [127:0] pt);
      int n;
      data_in_a[idx]  = ct;
      in_valid_a[idx] = 1'b1;
      n = 0;
      do begin @(negedge clk); n++; end while (in_ready_a[idx] !== 1'b1 && n < 300);
      if (n >= 300) checkOutput("in_accept_timeout", 128'd0, 128'd1);
      else begin
         exp_q.push_back(pt);
         exp_idx_q.push_back(idx);
      end
      @(posedge clk); #1;
      in_valid_a[idx] = 1'b0;
   endtask

   // Count clocks from the accept edge (edge 1) until out_valid shows.
   task automatic waitOutput(input int idx, output int lat);
      lat = 1;
      do begin @(posedge clk); #1; lat++; end while (out_valid_a[idx] !== 1'b1 && lat < 100);
   endtask

   // Scoreboard drain on every output handshake of any instance.
   always @(negedge clk) begin
      logic [127:0] e;
      int           ei;
      for (int i = 0; i < NI; i++) begin
         if (out_valid_a[i] === 1'b1 && out_ready_a[i] === 1'b1) begin
            if (exp_q.size() == 0) checkOutput("sb_unexpected_out", 128'(i), 128'hffff);
            else begin
               e  = exp_q.pop_front();
               ei = exp_idx_q.pop_front();
               checkOutput("sb_instance", 128'(i), 128'(ei));
               checkOutput("sb_data", data_out_a[i], e);
            end
         end
      end
   end

   // Random consumer backpressure for instance 0 during the random phase.
   always @(posedge clk) begin
      if (rand_ready) begin
         #1;
         out_ready_a[0] = 1'($urandom_range(0, 1));
      end
   end

   // Overall time limit so the run can never hang.
   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog expired");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int           lat;
      logic [127:0] rk, rp, rct;
      buildSbox();
      rst = 1'b1;
      for (int i = 0; i < NI; i++) begin
         key_a[i] = '0; key_valid_a[i] = 1'b0;
         data_in_a[i] = '0; in_valid_a[i] = 1'b0; out_ready_a[i] = 1'b1;
      end
      checkOutput("model_c1", modelEncrypt(C1_KEY, C1_PT), C1_CT);

      // Reset state, with a stray block offered while no key is present.
      in_valid_a[0] = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_out_valid", 128'(out_valid_a[0]), 128'd0);
      checkOutput("rst_data_out", data_out_a[0], 128'd0);
      checkOutput("rst_key_ready", 128'(key_ready_a[0]), 128'd1);
      checkOutput("rst_in_ready", 128'(in_ready_a[0]), 128'd0);
      checkOutput("rst_k10", g_dut[0].dut.k10_q, 128'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         checkOutput("idle_in_ready", 128'(in_ready_a[0]), 128'd0);
      end
      @(posedge clk); #1;
      in_valid_a[0] = 1'b0;

      // FIPS-197 C.1 at one round per cycle, with stored K10 and latency.
      $display("[TB] C.1 vector");
      loadKey(0, C1_KEY);
      checkOutput("c1_k10", g_dut[0].dut.k10_q, C1_K10);
      applyStimulus(0, C1_CT, C1_PT);
      waitOutput(0, lat);
      checkOutput("c1_latency", 128'(lat), 128'd11);

      // FIPS-197 App.B on each rounds-per-cycle variant.
      $display("[TB] App.B vector on all variants");
      for (int i = 0; i < NI; i++) begin
         loadKey(i, B_KEY);
         applyStimulus(i, B_CT, B_PT);
         waitOutput(i, lat);
         checkOutput("b_latency", 128'(lat), 128'(10 / RPC_T[i] + 1));
         repeat (2) @(posedge clk);
         #1;
      end

      // Backpressure: output held for 20 cycles, next block stalled.
      $display("[TB] backpressure");
      out_ready_a[0] = 1'b0;
      applyStimulus(0, B_CT, B_PT);
      waitOutput(0, lat);
      data_in_a[0]  = B_CT;
      in_valid_a[0] = 1'b1;
      repeat (20) begin
         @(negedge clk);
         checkOutput("bp_out_valid", 128'(out_valid_a[0]), 128'd1);
         checkOutput("bp_data_out", data_out_a[0], B_PT);
         checkOutput("bp_in_ready", 128'(in_ready_a[0]), 128'd0);
      end
      @(posedge clk); #1;
      out_ready_a[0] = 1'b1;
      @(posedge clk); #1;
      checkOutput("bp_release_valid", 128'(out_valid_a[0]), 128'd0);
      checkOutput("bp_release_key_ready", 128'(key_ready_a[0]), 128'd1);
      checkOutput("bp_release_in_ready", 128'(in_ready_a[0]), 128'd1);
      checkOutput("bp_data_hold", data_out_a[0], B_PT);
      applyStimulus(0, B_CT, B_PT);
      waitOutput(0, lat);
      @(posedge clk); #1;

      // Key and block offered together: key wins, block waits for new key.
      $display("[TB] key priority");
      key_a[0]       = C1_KEY;
      key_valid_a[0] = 1'b1;
      data_in_a[0]   = C1_CT;
      in_valid_a[0]  = 1'b1;
      @(negedge clk);
      checkOutput("prio_in_ready", 128'(in_ready_a[0]), 128'd0);
      checkOutput("prio_key_ready", 128'(key_ready_a[0]), 128'd1);
      @(posedge clk); #1;
      key_valid_a[0] = 1'b0;
      checkOutput("prio_kexp_key_ready", 128'(key_ready_a[0]), 128'd0);
      checkOutput("prio_kexp_in_ready", 128'(in_ready_a[0]), 128'd0);
      applyStimulus(0, C1_CT, C1_PT);
      waitOutput(0, lat);
      checkOutput("prio_latency", 128'(lat), 128'd11);
      @(posedge clk); #1;

      // Reset in the middle of a decryption.
      $display("[TB] reset mid-decrypt");
      applyStimulus(0, C1_CT, C1_PT);
      repeat (4) begin @(posedge clk); #1; end
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_out_valid", 128'(out_valid_a[0]), 128'd0);
      checkOutput("mid_rst_in_ready", 128'(in_ready_a[0]), 128'd0);
      checkOutput("mid_rst_key_ready", 128'(key_ready_a[0]), 128'd1);
      void'(exp_q.pop_back());
      void'(exp_idx_q.pop_back());
      @(posedge clk); #1;
      rst = 1'b0;
      data_in_a[0]  = C1_CT;
      in_valid_a[0] = 1'b1;
      repeat (12) begin
         @(negedge clk);
         checkOutput("no_key_in_ready", 128'(in_ready_a[0]), 128'd0);
         checkOutput("no_key_out_valid", 128'(out_valid_a[0]), 128'd0);
      end
      @(posedge clk); #1;
      in_valid_a[0] = 1'b0;

      // Random key/plaintext pairs through the reference encryptor.
      $display("[TB] random round trips");
      rand_ready = 1'b1;
      for (int v = 0; v < 1000; v++) begin
         rk  = {$urandom, $urandom, $urandom, $urandom};
         rp  = {$urandom, $urandom, $urandom, $urandom};
         rct = modelEncrypt(rk, rp);
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         loadKey(0, rk);
         repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         applyStimulus(0, rct, rp);
      end
      lat = 0;
      while (exp_q.size() != 0 && lat < 200) begin @(posedge clk); #1; lat++; end
      rand_ready = 1'b0;
      @(posedge clk); #1;
      out_ready_a[0] = 1'b1;
      checkOutput("sb_drained", 128'(exp_q.size()), 128'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
